serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial two's-complement subtractor: computes diff = a - b, one bit per clock, LSB first,
//  through a single 1-bit full-subtractor cell and a registered borrow. It is the inverse
//  arithmetic companion to the ripple full-adder datapath. It trades WIDTH cycles of latency
//  for one arithmetic cell, and is used where area matters more than throughput.
// PARAMETERS
//  WIDTH   8   operand/result width in bits (>= 2)
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      asynchronous, active-high reset
//  start       in   1      request; sampled when busy==0
//  a           in   WIDTH  minuend; captured on accepted start
//  b           in   WIDTH  subtrahend; captured on accepted start
//  busy        out  1      high while a subtraction is in progress
//  done        out  1      one-cycle pulse: diff/borrow_out valid
//  diff        out  WIDTH  result a - b mod 2^WIDTH; held until next accepted start
//  borrow_out  out  1      1 when unsigned a < b; held with diff
//  overflow    out  1      signed overflow (present only with SERIAL_SUB_OVERFLOW_EN)
// BEHAVIOUR
//  - Reset (async, any time incl. mid-operation): state=IDLE; busy=0, done=0, diff=0,
//    borrow_out=0, overflow=0; internal shift regs, borrow reg and bit counter cleared.
//  - FSM states IDLE, SHIFT, DONE; all outputs registered.
//    IDLE : start=1 -> capture a,b into shift regs, borrow reg=0, cnt=0 -> SHIFT.
//    SHIFT: each edge processes the LSBs ai, bi with borrow-in br:
//           d = ai^bi^br ; br_next = (~ai&bi) | (~(ai^bi)&br).
//           d shifts into the result MSB; the operands shift right; cnt++.
//           After the edge with cnt==WIDTH-1 -> DONE and load diff/borrow_out from the
//           final result/borrow.
//    DONE : done=1 for exactly this cycle. start=1 here is accepted (back-to-back)
//           -> SHIFT. Otherwise -> IDLE.
//  - busy=1 exactly in SHIFT. start while busy is ignored (operands are not re-sampled).
//  - Latency: start accepted at edge k -> done high in the cycle after edge k+WIDTH.
//    Throughput is one result per WIDTH+1 cycles.
//  - diff/borrow_out update only on entry to DONE. They are stable in IDLE and through the
//    next SHIFT phase.
//  - a==b gives diff=0, borrow_out=0. Wrap-around is mod 2^WIDTH (e.g. 0-1 = all ones,
//    borrow 1).
// CONFIGURATION
//  SERIAL_SUB_OVERFLOW_EN defined:
//    - overflow is a port.
//    - On entry to DONE, overflow = (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]), using the
//      captured operand sign bits.
//    - Cleared by reset; held like diff.
//  Not defined:
//    - No overflow port.
//    - Captured operand sign bits are not stored.
// STRUCTURE
//  - Package serial_sub_pkg: state encoding localparams (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2)
//    and the counter width function clog2(WIDTH).
//  - Sub-module full_subtractor_cell: combinational; ports ai, bi, bin -> d, bout.
//    Instantiated once.
//  - Top level: FSM, operand/result shift registers, borrow flop, counter.
// TESTING (WIDTH=8)
//  - 8'd100 - 8'd58 -> diff=8'd42, borrow_out=0. done exactly 9 edges after the start edge,
//    one cycle wide. busy high for 8 cycles.
//  - 8'd5 - 8'd10 -> diff=8'hFB, borrow_out=1. With the macro: overflow=0.
//  - 8'h80 - 8'h01 -> diff=8'h7F, borrow_out=0. With the macro: overflow=1.
//    8'h00 - 8'h00 -> diff=0, borrow 0.
//  - start pulsed with new a,b on SHIFT cycles 3 and 5 -> ignored; result matches the
//    first operands.
//  - start held high through DONE -> second op begins next edge with no IDLE cycle.
//    Both results are correct.
//  - rst asserted asynchronously mid-SHIFT (cycle 4) -> all outputs 0 immediately.
//    After release, a fresh start gives a correct result.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and
// counter sizing helper.
package serial_sub_pkg;

  localparam logic [1:0] IDLE_ENC  = 2'd0;
  localparam logic [1:0] SHIFT_ENC = 2'd1;
  localparam logic [1:0] DONE_ENC  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = IDLE_ENC,
    SHIFT = SHIFT_ENC,
    DONE  = DONE_ENC
  } state_t;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_subtractor_cell.sv
// One-bit full subtractor: d = ai - bi - bin, bout = borrow out.
// Purely combinational.
module full_subtractor_cell (
  input  logic ai,
  input  logic bi,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = ai ^ bi ^ bin;
  assign bout = (~ai & bi) | (~(ai ^ bi) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first: WIDTH cycles in SHIFT, then a one-cycle done pulse.
// Start is ignored while busy; accepted in IDLE or DONE. Optional signed overflow via SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
  output logic             borrow_out,
  output logic             overflow
`else
  output logic             borrow_out
`endif
);

  localparam int CW = clog2(WIDTH);

  state_t           state, state_nxt;
  // sa holds the minuend and fills from the top with result bits as it drains.
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d_bit;
  logic             bout_bit;
  logic             last;
  logic             load;

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic a_msb;
  logic b_msb;
`endif

  full_subtractor_cell u_cell (
    .ai   (sa[0]),
    .bi   (sb[0]),
    .bin  (br),
    .d    (d_bit),
    .bout (bout_bit)
  );

  assign last = (cnt == CW'(WIDTH - 1));
  assign load = start && ((state == IDLE) || (state == DONE));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == SHIFT);
      done  <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa         <= '0;
      sb         <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (load) begin
      sa  <= a;
      sb  <= b;
      br  <= 1'b0;
      cnt <= '0;
    end else if (state == SHIFT) begin
      sa  <= {d_bit, sa[WIDTH-1:1]};
      sb  <= {1'b0, sb[WIDTH-1:1]};
      br  <= bout_bit;
      cnt <= cnt + 1'b1;
      if (last) begin
        diff       <= {d_bit, sa[WIDTH-1:1]};
        borrow_out <= bout_bit;
      end
    end
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  // d_bit on the final edge is the result sign bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      overflow <= 1'b0;
    end else if (load) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if ((state == SHIFT) && last) begin
      overflow <= (a_msb != b_msb) && (d_bit != a_msb);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed, table-driven bench for serial_subtractor (WIDTH=8), plus
// hand-written sequences for ignored start, back-to-back and async reset.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic       overflow;
`endif

  int checks;
  int errors;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
`ifdef SERIAL_SUB_OVERFLOW_EN
    .borrow_out (borrow_out),
    .overflow   (overflow)
`else
    .borrow_out (borrow_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       brw;
    logic       ovf;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full operation; optionally pulses start with junk operands mid-SHIFT.
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                        input logic [7:0] ed, input logic eb, input logic eo,
                        input bit inject, input string tag);
    int edges;
    int bcnt;
    bit seen;
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    edges = 0; bcnt = 0; seen = 0;
    while (!seen && edges < 40) begin
      @(posedge clk); edges++;
      @(negedge clk);
      if (busy) bcnt++;
      if (done) seen = 1;
      else if (inject && (edges == 3 || edges == 5)) begin
        start = 1'b1; a = ~ia; b = ia;
      end else start = 1'b0;
    end
    start = 1'b0;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: no done after %0d edges", tag, edges);
    end
    chk({tag, " latency"}, edges, 9);
    chk({tag, " busy_cycles"}, bcnt, 8);
    chk({tag, " diff"}, {24'd0, diff}, {24'd0, ed});
    chk({tag, " borrow"}, {31'd0, borrow_out}, {31'd0, eb});
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk({tag, " overflow"}, {31'd0, overflow}, {31'd0, eo});
`else
    if (eo === 1'bx) $display("note: unexpected x in overflow expectation");
`endif
    @(posedge clk);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, {31'd0, done}, 32'd0);
    chk({tag, " diff_held"}, {24'd0, diff}, {24'd0, ed});
  endtask

  initial begin
    int edges;
    checks = 0;
    errors = 0;

    vecs[0] = '{8'd100, 8'd58, 8'd42,  1'b0, 1'b0};
    vecs[1] = '{8'd5,   8'd10, 8'hFB,  1'b1, 1'b0};
    vecs[2] = '{8'h80,  8'h01, 8'h7F,  1'b0, 1'b1};
    vecs[3] = '{8'h00,  8'h00, 8'h00,  1'b0, 1'b0};
    vecs[4] = '{8'h00,  8'h01, 8'hFF,  1'b1, 1'b0};
    vecs[5] = '{8'h7F,  8'hFF, 8'h80,  1'b1, 1'b1};
    vecs[6] = '{8'hFF,  8'hFF, 8'h00,  1'b0, 1'b0};
    vecs[7] = '{8'h80,  8'h7F, 8'h01,  1'b0, 1'b1};
    vecs[8] = '{8'hC8,  8'h64, 8'h64,  1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset diff", {24'd0, diff}, 32'd0);
    chk("reset borrow", {31'd0, borrow_out}, 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("reset overflow", {31'd0, overflow}, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].brw, vecs[i].ovf, 1'b0,
             $sformatf("vec%0d", i));

    // start pulsed on SHIFT cycles 3 and 5 with different operands
    run_op(8'd100, 8'd58, 8'd42, 1'b0, 1'b0, 1'b1, "ignore_start");

    // back-to-back: start held high through DONE
    @(negedge clk);
    a = 8'd100; b = 8'd58; start = 1'b1;
    edges = 0;
    while (!done && edges < 40) begin
      @(posedge clk); edges++;
      @(negedge clk);
    end
    chk("b2b first latency", edges, 9);
    chk("b2b first diff", {24'd0, diff}, 32'd42);
    a = 8'd5; b = 8'd10;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("b2b no idle busy", {31'd0, busy}, 32'd1);
    chk("b2b diff held in shift", {24'd0, diff}, 32'd42);
    edges = 0;
    while (!done && edges < 40) begin
      @(posedge clk); edges++;
      @(negedge clk);
    end
    chk("b2b second latency", edges, 8);
    chk("b2b second diff", {24'd0, diff}, 32'hFB);
    chk("b2b second borrow", {31'd0, borrow_out}, 32'd1);

    // async reset in the middle of SHIFT
    @(negedge clk);
    a = 8'hC8; b = 8'h64; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst busy", {31'd0, busy}, 32'd0);
    chk("arst done", {31'd0, done}, 32'd0);
    chk("arst diff", {24'd0, diff}, 32'd0);
    chk("arst borrow", {31'd0, borrow_out}, 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("arst overflow", {31'd0, overflow}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    run_op(8'hC8, 8'h64, 8'h64, 1'b0, 1'b1, 1'b0, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
